// File: rtl/register_display.sv
// register_display
// Converts a register value to BCD with a sequential double-dabble engine and
// drives a multiplexed common-anode 7-segment display with leading-zero blanking.
// The committed BCD value changes only when a conversion completes, so the
// display never shows a partially converted number.
//
// Ports:
//   clock          in   1                 system clock, rising edge
//   isResetN       in   1                 asynchronous active-low reset
//   register1Value in   REGISTER_WIDTH    value to display, may change any cycle
//   bcd            out  4*NUM_DIGITS      committed BCD value, ones digit in [3:0]
//   busy           out  1                 high while a conversion is running
//   anodes         out  NUM_DIGITS        active-low digit enables, one-hot-low
//   segments       out  7                 active-low segments {g,f,e,d,c,b,a}
module register_display #(
    parameter int REGISTER_WIDTH  = 8,
    parameter int NUM_DIGITS      = 3,
    parameter int REFRESH_DIVIDER = 1024
) (
    input  logic                        clock,
    input  logic                        isResetN,
    input  logic [REGISTER_WIDTH-1:0]   register1Value,
    output logic [4*NUM_DIGITS-1:0]     bcd,
    output logic                        busy,
    output logic [NUM_DIGITS-1:0]       anodes,
    output logic [6:0]                  segments
);

    localparam int BCD_W   = 4 * NUM_DIGITS;
    localparam int SHIFT_W = BCD_W + REGISTER_WIDTH;
    localparam int CNT_W   = $clog2(REGISTER_WIDTH + 1);
    localparam int REF_W   = $clog2(REFRESH_DIVIDER);
    localparam int DIG_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(REGISTER_WIDTH - 1);
    localparam logic [REF_W-1:0] REF_LAST   = REF_W'(REFRESH_DIVIDER - 1);
    localparam logic [DIG_W-1:0] DIG_LAST   = DIG_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // One double-dabble step: correct every BCD nibble >= 5, then shift left.
    function automatic logic [SHIFT_W-1:0] dabble_step(input logic [SHIFT_W-1:0] s);
        logic [SHIFT_W-1:0] a;
        a = s;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (a[REGISTER_WIDTH + 4*i +: 4] >= 4'd5) begin
                a[REGISTER_WIDTH + 4*i +: 4] = a[REGISTER_WIDTH + 4*i +: 4] + 4'd3;
            end else begin
                a[REGISTER_WIDTH + 4*i +: 4] = a[REGISTER_WIDTH + 4*i +: 4];
            end
        end
        return {a[SHIFT_W-2:0], 1'b0};
    endfunction

    // Active-low 7-segment pattern for one BCD digit; non-decimal codes go dark.
    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    state_t                     state_q, state_d;
    logic [REGISTER_WIDTH-1:0]  last_value_q, last_value_d;
    logic [SHIFT_W-1:0]         shift_q, shift_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic                       busy_q, busy_d;
    logic [BCD_W-1:0]           bcd_q, bcd_d;
    logic [REF_W-1:0]           refresh_q, refresh_d;
    logic [DIG_W-1:0]           digit_idx_q, digit_idx_d;
    logic [NUM_DIGITS-1:0]      anodes_q, anodes_d;
    logic [6:0]                 segments_q, segments_d;

    logic [NUM_DIGITS-1:0]      lead_zero_s;
    logic                       run_zero_s;
    logic [3:0]                 nibble_s;

    // Conversion FSM next-state: detect a new value, shift it through, commit once.
    always_comb begin
        state_d      = state_q;
        last_value_d = last_value_q;
        shift_d      = shift_q;
        count_d      = count_q;
        busy_d       = busy_q;
        bcd_d        = bcd_q;
        case (state_q)
            ST_IDLE: begin
                if (register1Value != last_value_q) begin
                    last_value_d = register1Value;
                    shift_d      = {{BCD_W{1'b0}}, register1Value};
                    count_d      = {CNT_W{1'b0}};
                    busy_d       = 1'b1;
                    state_d      = ST_SHIFT;
                end else begin
                    state_d      = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                shift_d = dabble_step(shift_q);
                count_d = count_q + CNT_W'(1'b1);
                if (count_q == LAST_SHIFT) begin
                    state_d = ST_COMMIT;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_COMMIT: begin
                bcd_d   = shift_q[SHIFT_W-1 -: BCD_W];
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Scan next-state: refresh divider, digit index and the registered display drive.
    always_comb begin
        refresh_d   = refresh_q;
        digit_idx_d = digit_idx_q;
        if (refresh_q == REF_LAST) begin
            refresh_d = {REF_W{1'b0}};
            if (digit_idx_q == DIG_LAST) begin
                digit_idx_d = {DIG_W{1'b0}};
            end else begin
                digit_idx_d = digit_idx_q + DIG_W'(1'b1);
            end
        end else begin
            refresh_d = refresh_q + REF_W'(1'b1);
        end

        // lead_zero_s[i] is set when digit i and every digit above it are zero.
        run_zero_s  = 1'b1;
        lead_zero_s = {NUM_DIGITS{1'b0}};
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run_zero_s     = run_zero_s & (bcd_q[4*i +: 4] == 4'd0);
            lead_zero_s[i] = run_zero_s;
        end

        nibble_s = bcd_q[{digit_idx_q, 2'b00} +: 4];
        anodes_d = ~(NUM_DIGITS'(1'b1) << digit_idx_q);
        if ((digit_idx_q != {DIG_W{1'b0}}) && lead_zero_s[digit_idx_q]) begin
            segments_d = 7'h7F;
        end else begin
            segments_d = seg_decode(nibble_s);
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clock or negedge isResetN) begin
        if (!isResetN) begin
            state_q      <= ST_IDLE;
            last_value_q <= {REGISTER_WIDTH{1'b0}};
            shift_q      <= {SHIFT_W{1'b0}};
            count_q      <= {CNT_W{1'b0}};
            busy_q       <= 1'b0;
            bcd_q        <= {BCD_W{1'b0}};
            refresh_q    <= {REF_W{1'b0}};
            digit_idx_q  <= {DIG_W{1'b0}};
            anodes_q     <= {NUM_DIGITS{1'b1}};
            segments_q   <= 7'h7F;
        end else begin
            state_q      <= state_d;
            last_value_q <= last_value_d;
            shift_q      <= shift_d;
            count_q      <= count_d;
            busy_q       <= busy_d;
            bcd_q        <= bcd_d;
            refresh_q    <= refresh_d;
            digit_idx_q  <= digit_idx_d;
            anodes_q     <= anodes_d;
            segments_q   <= segments_d;
        end
    end

    assign bcd      = bcd_q;
    assign busy     = busy_q;
    assign anodes   = anodes_q;
    assign segments = segments_q;

endmodule

// File: tb/tb_register_display.sv
module tb_register_display;

    logic        clock;
    logic        isResetN;
    logic [7:0]  register1Value;
    logic [11:0] bcd;
    logic        busy;
    logic [2:0]  anodes;
    logic [6:0]  segments;

    int checks;
    int errors;

    typedef struct {
        logic [7:0]  value;
        logic [11:0] exp_bcd;
        logic [6:0]  seg2;
        logic [6:0]  seg1;
        logic [6:0]  seg0;
    } vec_t;

    vec_t vecs[11];

    register_display #(
        .REGISTER_WIDTH (8),
        .NUM_DIGITS     (3),
        .REFRESH_DIVIDER(4)
    ) dut (
        .clock         (clock),
        .isResetN      (isResetN),
        .register1Value(register1Value),
        .bcd           (bcd),
        .busy          (busy),
        .anodes        (anodes),
        .segments      (segments)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock edge, then settle so outputs are sampled away from the edge.
    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    function automatic logic [11:0] ref_bcd(input int v);
        return 12'((v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10));
    endfunction

    // Value is already on register1Value and not yet sampled; it is sampled on the
    // first edge here. busy must be high after edges 1..9, bcd new after edge 10.
    task automatic wait_conv(input string name, input logic [11:0] exp, input logic [11:0] prev);
        int busy_cnt;
        busy_cnt = 0;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            if (k <= 9) busy_cnt += int'(busy);
            if (k == 9) check({name, "_no_partial"}, 32'(bcd), 32'(prev));
        end
        check({name, "_busy_cycles"}, 32'(busy_cnt), 32'd9);
        check({name, "_busy_done"}, 32'(busy), 32'd0);
        check({name, "_bcd"}, 32'(bcd), 32'(exp));
    endtask

    // Watch a full scan period and compare each lit digit against its pattern.
    task automatic check_display(input string name, input logic [6:0] s2,
                                 input logic [6:0] s1, input logic [6:0] s0);
        logic [2:0] seen;
        seen = 3'b000;
        cyc();
        for (int k = 0; k < 13; k++) begin
            case (anodes)
                3'b110: begin check({name, "_d0"}, 32'(segments), 32'(s0)); seen[0] = 1'b1; end
                3'b101: begin check({name, "_d1"}, 32'(segments), 32'(s1)); seen[1] = 1'b1; end
                3'b011: begin check({name, "_d2"}, 32'(segments), 32'(s2)); seen[2] = 1'b1; end
                default: check({name, "_anodes_onehot"}, 32'(anodes), 32'h6);
            endcase
            cyc();
        end
        check({name, "_all_digits"}, 32'(seen), 32'h7);
    endtask

    initial begin
        logic [2:0]  an_seq[3];
        logic [11:0] cur_bcd;
        int          v;
        checks = 0;
        errors = 0;
        an_seq[0] = 3'b110;
        an_seq[1] = 3'b101;
        an_seq[2] = 3'b011;

        vecs[0]  = '{8'd255, 12'h255, 7'h24, 7'h12, 7'h12};
        vecs[1]  = '{8'd7,   12'h007, 7'h7F, 7'h7F, 7'h78};
        vecs[2]  = '{8'd42,  12'h042, 7'h7F, 7'h19, 7'h24};
        vecs[3]  = '{8'd100, 12'h100, 7'h79, 7'h40, 7'h40};
        vecs[4]  = '{8'd9,   12'h009, 7'h7F, 7'h7F, 7'h10};
        vecs[5]  = '{8'd10,  12'h010, 7'h7F, 7'h79, 7'h40};
        vecs[6]  = '{8'd99,  12'h099, 7'h7F, 7'h10, 7'h10};
        vecs[7]  = '{8'd200, 12'h200, 7'h24, 7'h40, 7'h40};
        vecs[8]  = '{8'd128, 12'h128, 7'h79, 7'h24, 7'h00};
        vecs[9]  = '{8'd1,   12'h001, 7'h7F, 7'h7F, 7'h79};
        vecs[10] = '{8'd0,   12'h000, 7'h7F, 7'h7F, 7'h40};

        // Reset with value 0 held.
        isResetN       = 1'b0;
        register1Value = 8'd0;
        repeat (2) @(posedge clock);
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_bcd", 32'(bcd), 32'h000);
        check("rst_anodes", 32'(anodes), 32'h7);
        check("rst_segments", 32'(segments), 32'h7F);
        isResetN = 1'b1;

        // Scan order with divider 4: each digit lit for 4 clocks.
        for (int k = 1; k <= 16; k++) begin
            cyc();
            check($sformatf("scan_edge%0d", k), 32'(anodes), 32'(an_seq[((k - 1) / 4) % 3]));
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_bcd", 32'(bcd), 32'h000);
        end
        check_display("zero", 7'h7F, 7'h7F, 7'h40);

        // Table-driven conversions.
        cur_bcd = 12'h000;
        for (int i = 0; i < 11; i++) begin
            register1Value = vecs[i].value;
            wait_conv($sformatf("vec%0d", i), vecs[i].exp_bcd, cur_bcd);
            check_display($sformatf("vec%0d", i), vecs[i].seg2, vecs[i].seg1, vecs[i].seg0);
            cur_bcd = vecs[i].exp_bcd;
        end

        // 7 then 42 arriving mid-conversion.
        register1Value = 8'd7;
        repeat (3) cyc();
        register1Value = 8'd42;
        repeat (7) cyc();
        check("seq7_bcd", 32'(bcd), 32'h007);
        check("seq7_busy", 32'(busy), 32'd0);
        wait_conv("seq42", 12'h042, 12'h007);
        check_display("seq42", 7'h7F, 7'h19, 7'h24);

        // Value returns to lastValue before IDLE: no second conversion.
        register1Value = 8'd60;
        repeat (2) cyc();
        register1Value = 8'd70;
        repeat (2) cyc();
        register1Value = 8'd60;
        repeat (6) cyc();
        check("ret_bcd", 32'(bcd), 32'h060);
        for (int k = 0; k < 10; k++) begin
            cyc();
            check("ret_no_busy", 32'(busy), 32'd0);
        end
        check("ret_bcd_hold", 32'(bcd), 32'h060);

        // Reset in the middle of a conversion of 200.
        register1Value = 8'd200;
        repeat (4) cyc();
        check("mid_busy", 32'(busy), 32'd1);
        isResetN = 1'b0;
        #1;
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_bcd", 32'(bcd), 32'h000);
        check("mrst_anodes", 32'(anodes), 32'h7);
        check("mrst_segments", 32'(segments), 32'h7F);
        cyc();
        check("mrst_hold_anodes", 32'(anodes), 32'h7);
        isResetN = 1'b1;
        wait_conv("after_rst", 12'h200, 12'h000);
        check_display("after_rst", 7'h24, 7'h40, 7'h40);

        // Exhaustive against a decimal reference; order avoids repeating lastValue.
        cur_bcd = 12'h200;
        for (int i = 0; i < 256; i++) begin
            v = (201 + i) % 256;
            register1Value = 8'(v);
            wait_conv($sformatf("ex%0d", v), ref_bcd(v), cur_bcd);
            cur_bcd = ref_bcd(v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
